imem_loader: RTL and testbench

Byte-serial program loader that writes the instruction memory of the multicycle RISC-V core, the write-side counterpart to the control unit's instruction fetch path. While it runs, it holds the processor in reset. It receives a length-prefixed little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit words and drives `IMemWrite`, the address and the data into instruction memory. It sits between the host link (UART/testbench byte source) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Build option: define IMEM_LOADER_CHECKSUM_EN to append an XOR checksum byte to the stream.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte shift buffer; wordReady pulses for one cycle after the 4th byte lands.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byteIn,
  output logic [WORD_W-1:0] word,
  output logic [IDX_W-1:0]  byteIdx,
  output logic              wordReady
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word      <= '0;
      byteIdx   <= '0;
      wordReady <= 1'b0;
    end else begin
      wordReady <= 1'b0;
      if (shift) begin
        // New bytes enter at the top so the first byte ends up in [7:0].
        word      <= {byteIn, word[WORD_W-1:BYTE_W]};
        byteIdx   <= byteIdx + IDX_W'(1);
        wordReady <= (byteIdx == IDX_W'(WORD_BYTES - 1));
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial loader that fills instruction memory and holds the core in reset meanwhile.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CHECK state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              IMemWrite,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  loader_state_t     state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  wordCnt;
  logic [LEN_W-1:0]  lenNext;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  byteIdx;
  logic              wordReady;
  logic              accept;
  logic              restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  // Handshake and status outputs decode straight from the state register.
  assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHECK);
  assign cpu_hold   = (state != IDLE) && (state != DONE);
  assign accept     = byte_valid && byte_ready;
  assign restart    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign lenNext    = {byte_in, len[BYTE_W-1:0]};

  assign IMemWrite  = wordReady;
  assign imem_addr  = addr;
  assign imem_wdata = word;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .shift    (accept && (state == DATA)),
    .byteIn   (byte_in),
    .word     (word),
    .byteIdx  (byteIdx),
    .wordReady(wordReady)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      wordCnt <= '0;
      addr    <= ADDR_W'(BASE_ADDR);
      done    <= 1'b0;
      error   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (restart) begin
            state   <= LEN_LO;
            wordCnt <= '0;
            addr    <= ADDR_W'(BASE_ADDR);
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[BYTE_W-1:0] <= byte_in;
            state           <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[LEN_W-1:BYTE_W] <= byte_in;
            if ((lenNext == '0) || (32'(lenNext) > MAX_WORDS)) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            if (byteIdx == IDX_W'(WORD_BYTES - 1)) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          addr    <= addr + ADDR_W'(WORD_BYTES);
          wordCnt <= wordCnt + LEN_W'(1);
          if ((wordCnt + LEN_W'(1)) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (byte_in == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: timing, length bounds, stalls, mid-load reset, optional checksum.
module tb_imem_loader;

  localparam int unsigned MAXW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        IMemWrite;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int c0          = 0;

  logic [31:0] wAddr[$];
  logic [31:0] wData[$];
  logic [7:0]  stream[$];

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .IMemWrite (IMemWrite),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Memory-side log of every write strobe.
  always @(posedge clk) begin
    cyc++;
    if (IMemWrite) begin
      wAddr.push_back(imem_addr);
      wData.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_timeout: ready=%b want 1", byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic begin_load();
    wAddr.delete();
    wData.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  // Sends the queued stream; with checksum builds a trailing XOR of the data bytes follows.
  task automatic send_stream(input int maxGap, input logic [7:0] tailXor);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < stream.size(); i++) begin
      if (i >= 2) x ^= stream[i];
      send_byte(stream[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x ^ tailXor, 0);
`else
    x ^= tailXor;
`endif
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(output int cycles, output int holdBad);
    int n = 0;
    holdBad = 0;
    while (!(done || error) && n < 400) begin
      if (!cpu_hold) holdBad++;
      @(negedge clk);
      n++;
    end
    cycles = cyc - c0;
    if (!(done || error)) begin
      vectors++;
      miscompares++;
      $display("FAIL end_timeout: done=%b error=%b want one set", done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({byte_ready, IMemWrite, cpu_hold, done, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {byte_ready, IMemWrite, cpu_hold, done, error});
    end
    vectors++;
    if (imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 00000000", imem_addr);
    end
    vectors++;
    if (imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h want 00000000", imem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int cycles, holdBad;
    int expCycles = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    expCycles = 13;
`endif
    begin_load();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(0, 8'h00);
    wait_end(cycles, holdBad);
    vectors++;
    if (cycles !== expCycles) begin
      miscompares++;
      $display("FAIL basic_cycles: got %0d want %0d", cycles, expCycles);
    end
    vectors++;
    if ({done, error, cpu_hold} !== 3'b100 || holdBad !== 0) begin
      miscompares++;
      $display("FAIL basic_status: done/err/hold=%b holdBad=%0d want 100 0", {done, error, cpu_hold}, holdBad);
    end
    vectors++;
    if (wAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL basic_count: got %0d writes want 2", wAddr.size());
    end else begin
      vectors++;
      if (wAddr[0] !== 32'h0 || wData[0] !== 32'h12345678) begin
        miscompares++;
        $display("FAIL basic_word0: got %h@%h want 12345678@00000000", wData[0], wAddr[0]);
      end
      vectors++;
      if (wAddr[1] !== 32'h4 || wData[1] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL basic_word1: got %h@%h want deadbeef@00000004", wData[1], wAddr[1]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold_done: done=%b ready=%b want 1 0", done, byte_ready);
    end
  endtask

  task automatic test_zero_len();
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    vectors++;
    if ({error, cpu_hold, done, byte_ready} !== 4'b1100) begin
      miscompares++;
      $display("FAIL zero_len_status: err/hold/done/ready=%b want 1100", {error, cpu_hold, done, byte_ready});
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (wAddr.size() !== 0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_len_writes: writes=%0d error=%b want 0 1", wAddr.size(), error);
    end
  endtask

  task automatic test_overlength();
    begin_load();
    send_byte(8'(MAXW + 1), 0);
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    vectors++;
    if ({error, cpu_hold, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL overlength: err/hold/done=%b want 110", {error, cpu_hold, done});
    end
  endtask

  task automatic test_max_len();
    int cycles, holdBad;
    int bad = 0;
    begin_load();
    stream = '{8'(MAXW), 8'h00};
    for (int j = 0; j < 4 * MAXW; j++) stream.push_back(8'(j));
    send_stream(0, 8'h00);
    wait_end(cycles, holdBad);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || wAddr.size() !== MAXW) begin
      miscompares++;
      $display("FAIL max_status: done=%b err=%b writes=%0d want 1 0 %0d", done, error, wAddr.size(), MAXW);
    end else begin
      for (int i = 0; i < MAXW; i++) begin
        if (wAddr[i] !== 32'(4 * i) ||
            wData[i] !== {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)}) bad++;
      end
      vectors++;
      if (wAddr[MAXW-1] !== 32'(4 * (MAXW - 1)) || wData[MAXW-1] !== 32'hFFFEFDFC) begin
        miscompares++;
        $display("FAIL max_last: got %h@%h want fffefdfc@%h", wData[MAXW-1], wAddr[MAXW-1], 32'(4 * (MAXW - 1)));
      end
      vectors++;
      if (bad !== 0) begin
        miscompares++;
        $display("FAIL max_contents: %0d bad words want 0", bad);
      end
    end
  endtask

  task automatic test_stall_start();
    int cycles, holdBad;
    begin_load();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56};
    send_stream_part(3);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream_part(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A, 2);
`endif
    byte_valid = 1'b0;
    wait_end(cycles, holdBad);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || holdBad !== 0) begin
      miscompares++;
      $display("FAIL stall_status: done=%b err=%b holdBad=%0d want 1 0 0", done, error, holdBad);
    end
    vectors++;
    if (wAddr.size() !== 2) begin
      miscompares++;
      $display("FAIL stall_count: got %0d writes want 2", wAddr.size());
    end else begin
      vectors++;
      if (wData[0] !== 32'h12345678 || wData[1] !== 32'hDEADBEEF || wAddr[1] !== 32'h4) begin
        miscompares++;
        $display("FAIL stall_words: got %h %h@%h want 12345678 deadbeef@00000004", wData[0], wData[1], wAddr[1]);
      end
    end
  endtask

  task automatic send_stream_part(input int maxGap);
    for (int i = 0; i < stream.size(); i++)
      send_byte(stream[i], int'($urandom_range(0, maxGap)));
  endtask

  task automatic test_reset_midload();
    begin_load();
    stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_stream_part(0);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    vectors++;
    if ({byte_ready, IMemWrite, cpu_hold, done, error} !== 5'b0 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: flags=%b addr=%h wdata=%h want 00000 0 0",
               {byte_ready, IMemWrite, cpu_hold, done, error}, imem_addr, imem_wdata);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (wAddr.size() !== 1) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d writes want 1", wAddr.size());
    end else begin
      vectors++;
      if (wData[0] !== 32'h44332211 || wAddr[0] !== 32'h0) begin
        miscompares++;
        $display("FAIL midreset_word0: got %h@%h want 44332211@00000000", wData[0], wAddr[0]);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int cycles, holdBad;
    begin_load();
    stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(0, 8'h00);
    wait_end(cycles, holdBad);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || wData.size() !== 1) begin
      miscompares++;
      $display("FAIL csum_good: done=%b err=%b writes=%0d want 1 0 1", done, error, wData.size());
    end
    begin_load();
    send_stream(0, 8'h01);
    wait_end(cycles, holdBad);
    vectors++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL csum_bad: err=%b done=%b hold=%b want 1 0 1", error, done, cpu_hold);
    end
    vectors++;
    if (wData.size() !== 1 || wData[0] !== 32'h04030201) begin
      miscompares++;
      $display("FAIL csum_bad_word: writes=%0d word=%h want 1 04030201", wData.size(),
               (wData.size() > 0) ? wData[0] : 32'h0);
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_zero_len();
    test_overlength();
    test_max_len();
    test_stall_start();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
